uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Groups the serial line and the received-byte signals of uart_rx.
//   rx_serial    : serial line, idle high (driven by the line side)
//   rx_dv        : one-cycle pulse, rx_byte holds a newly received byte
//   rx_byte      : last correctly framed byte
//   rx_frame_err : one-cycle pulse, stop bit was sampled low
//   rx_active    : receiver is busy with a frame
// master = the side that drives the line; slave = the receiver.
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic       rx_serial;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_frame_err;
    logic       rx_active;

    modport master (
        output rx_serial,
        input  rx_dv,
        input  rx_byte,
        input  rx_frame_err,
        input  rx_active
    );

    modport slave (
        input  rx_serial,
        output rx_dv,
        output rx_byte,
        output rx_frame_err,
        output rx_active
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver (1 start bit, 8 data bits LSB first, 1 stop bit).
// Parameter:
//   CLKS_PER_BIT   : i_Clock cycles per bit period (4..65535)
// Ports:
//   i_Clock        : clock, rising edge
//   i_Rst          : synchronous active-high reset
//   i_RX_Serial    : asynchronous serial input, idle high
//   o_RX_DV        : one-cycle pulse when o_RX_Byte is updated
//   o_RX_Byte      : last correctly framed byte, held until the next one
//   o_RX_Frame_Err : one-cycle pulse when the stop bit is sampled low
//   o_RX_Active    : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Active
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4
    } state_t;

    logic          meta_r;
    logic          line_r;
    state_t        state_r,   state_s;
    logic [CW-1:0] cnt_r,     cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r,   shift_s;
    logic [7:0]    byte_r,    byte_s;
    logic          dv_r,      dv_s;
    logic          ferr_r,    ferr_s;
    logic          active_r,  active_s;
    // settle_r counts the cycles until line_r reflects the real input again
    // after reset; armed_r then records that the line has been seen high,
    // so a frame cut by reset is not mistaken for a new start bit.
    logic [1:0]    settle_r,  settle_s;
    logic          armed_r,   armed_s;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            meta_r <= 1'b1;
            line_r <= 1'b1;
        end else begin
            meta_r <= i_RX_Serial;
            line_r <= meta_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            byte_r    <= 8'h00;
            dv_r      <= 1'b0;
            ferr_r    <= 1'b0;
            active_r  <= 1'b0;
            settle_r  <= 2'd0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            byte_r    <= byte_s;
            dv_r      <= dv_s;
            ferr_r    <= ferr_s;
            active_r  <= active_s;
            settle_r  <= settle_s;
            armed_r   <= armed_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        byte_s    = byte_r;
        dv_s      = 1'b0;
        ferr_s    = 1'b0;

        if (settle_r == 2'd2) begin
            settle_s = settle_r;
        end else begin
            settle_s = settle_r + 2'd1;
        end
        armed_s = armed_r | ((settle_r == 2'd2) & line_r);

        case (state_r)
            IDLE: begin
                cnt_s     = '0;
                bit_idx_s = 3'd0;
                if (armed_r && !line_r) begin
                    state_s = RX_START_BIT;
                end else begin
                    state_s = IDLE;
                end
            end
            RX_START_BIT: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_r == HALF_CNT) begin
                    cnt_s = '0;
                    if (!line_r) begin
                        state_s = RX_DATA_BITS;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RX_DATA_BITS: begin
                if (cnt_r == LAST_CNT) begin
                    cnt_s            = '0;
                    shift_s[bit_idx_r] = line_r;
                    if (bit_idx_r < 3'd7) begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end else begin
                        bit_idx_s = 3'd0;
                        state_s   = RX_STOP_BIT;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RX_STOP_BIT: begin
                if (cnt_r == LAST_CNT) begin
                    cnt_s   = '0;
                    state_s = CLEANUP;
                    if (line_r) begin
                        byte_s = shift_r;
                        dv_s   = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            CLEANUP: begin
                cnt_s   = '0;
                state_s = IDLE;
            end
            default: begin
                cnt_s     = '0;
                bit_idx_s = 3'd0;
                state_s   = IDLE;
            end
        endcase

        // Registered from the next state so it tracks state_r exactly.
        active_s = (state_s != IDLE);
    end

    assign o_RX_DV        = dv_r;
    assign o_RX_Byte      = byte_r;
    assign o_RX_Frame_Err = ferr_r;
    assign o_RX_Active    = active_r;

endmodule
